// File: rtl/bcd_pkg.sv
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared definitions for the bcd2bin_n converter: digit width,
//                FSM state encoding and the minimum result width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    // Width of one packed BCD digit
    localparam int DIGIT_W = 4;

    // FSM state encoding; the fourth 2-bit code is unused and recovers to idle
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OP   = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_OP   = ST_OP,
        S_DONE = ST_DONE
    } state_t;

    // Smallest result width w such that 2^w >= 10^digits
    function automatic int min_bin_w(input int digits);
        longint unsigned p;
        int              w;
        bit              found;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        w     = 0;
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (!found && ((64'd1 << i) >= p)) begin
                w     = i;
                found = 1'b1;
            end
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// ============================================================================
//  Module      : bcd_digit_adj
//  Description : One BCD digit correction cell: after a right shift, a digit
//                of 8 or more has 3 subtracted (4-bit arithmetic).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    // A halved digit that reads >= 8 carried a 10 worth 5 at this weight; fix by -3
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= 4'd8) begin
            o_digit = i_digit - 4'd3;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bcd2bin_n.sv
// ============================================================================
//  Module      : bcd2bin_n
//  Description : Multi-digit BCD to binary converter. Iterative shift right /
//                subtract-3 datapath, one shift per clock, start/ready/
//                done_tick handshake.
//  Options     : BCD2BIN_DIGIT_CHECK_EN - reject jobs containing a nibble > 9,
//                reporting err=1 and bin=0 one cycle after the accept edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd2bin_n
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
)
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [DIGIT_W*DIGITS-1:0]   bcd,
    output logic                        ready,
    output logic                        done_tick,
    output logic                        err,
    output logic [BIN_W-1:0]            bin
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int TOT_W = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    // Result width must be exactly the minimum able to hold 10^DIGITS - 1
    generate
        if (BIN_W != min_bin_w(DIGITS)) begin : g_bin_w_check
            $error("bcd2bin_n: BIN_W does not match the width required by DIGITS");
        end
    endgenerate

    state_t               r_state;
    state_t               w_state_nxt;
    logic [BCD_W-1:0]     r_bcd;
    logic [BCD_W-1:0]     w_bcd_nxt;
    logic [BIN_W-1:0]     r_bin;
    logic [BIN_W-1:0]     w_bin_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;

    logic [TOT_W-1:0]     w_shift;
    logic [BCD_W-1:0]     w_bcd_shift;
    logic [BCD_W-1:0]     w_bcd_adj;
    logic [BIN_W-1:0]     w_bin_shift;

    // One step of the conversion: the combined register moves right by one,
    // the lowest BCD bit becomes the new binary MSB
    assign w_shift     = {r_bcd, r_bin} >> 1;
    assign w_bcd_shift = w_shift[TOT_W-1:BIN_W];
    assign w_bin_shift = w_shift[BIN_W-1:0];

    // Per-digit correction applied in parallel after each shift
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .i_digit (w_bcd_shift[gi*DIGIT_W +: DIGIT_W]),
                .o_digit (w_bcd_adj[gi*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic r_err;
    logic w_err_nxt;
    logic w_bcd_bad;

    // Flag any incoming nibble that is not a decimal digit
    always_comb begin
        w_bcd_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[i*DIGIT_W +: DIGIT_W] > 4'd9) begin
                w_bcd_bad = 1'b1;
            end
        end
    end
`endif

    // Next-state, datapath next values and Moore handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        w_bcd_nxt   = r_bcd;
        w_bin_nxt   = r_bin;
        w_cnt_nxt   = r_cnt;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        w_err_nxt   = r_err;
`endif
        ready       = 1'b0;
        done_tick   = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_bcd_nxt = bcd;
                    w_cnt_nxt = CNT_W'(BIN_W);
`ifdef BCD2BIN_DIGIT_CHECK_EN
                    if (w_bcd_bad) begin
                        // Invalid job: report straight away, no iterations
                        w_err_nxt   = 1'b1;
                        w_bin_nxt   = '0;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_err_nxt   = 1'b0;
                        w_state_nxt = S_OP;
                    end
`else
                    w_state_nxt = S_OP;
`endif
                end
            end
            S_OP: begin
                w_bcd_nxt = w_bcd_adj;
                w_bin_nxt = w_bin_shift;
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done_tick   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any job in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_bcd   <= '0;
            r_bin   <= '0;
            r_cnt   <= '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_bcd   <= w_bcd_nxt;
            r_bin   <= w_bin_nxt;
            r_cnt   <= w_cnt_nxt;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            r_err   <= w_err_nxt;
`endif
        end
    end

    assign bin = r_bin;

`ifdef BCD2BIN_DIGIT_CHECK_EN
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcd2bin_n.sv
// ============================================================================
//  Module      : tb_bcd2bin_n
//  Description : Self-checking bench for bcd2bin_n (3-digit and 4-digit
//                instances) against a decimal-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bcd2bin_n;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        start3 = 1'b0;
    logic        start4 = 1'b0;
    logic [11:0] bcd3   = '0;
    logic [15:0] bcd4   = '0;
    logic        ready3, done3, err3;
    logic [9:0]  bin3;
    logic        ready4, done4, err4;
    logic [13:0] bin4;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef BCD2BIN_DIGIT_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    bcd2bin_n #(.DIGITS(3), .BIN_W(10)) u_dut3 (
        .clk       (clk),
        .reset     (reset),
        .start     (start3),
        .bcd       (bcd3),
        .ready     (ready3),
        .done_tick (done3),
        .err       (err3),
        .bin       (bin3)
    );

    bcd2bin_n #(.DIGITS(4), .BIN_W(14)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .start     (start4),
        .bcd       (bcd4),
        .ready     (ready4),
        .done_tick (done4),
        .err       (err4),
        .bin       (bin4)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input int exp_v);
        n_checks++;
        if (obs !== 32'(exp_v)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Reference: plain decimal weighting of the nibbles
    function automatic void ref_model(input logic [15:0] v, input int digits,
                                      output int val, output bit bad);
        int scale;
        val   = 0;
        bad   = 1'b0;
        scale = 1;
        for (int i = 0; i < digits; i++) begin
            int d;
            d = int'(v[i*4 +: 4]);
            if (d > 9) bad = 1'b1;
            val   = val + d * scale;
            scale = scale * 10;
        end
    endfunction

    function automatic logic [15:0] rand_bcd(input int digits);
        logic [15:0] v;
        v = '0;
        for (int k = 0; k < digits; k++) begin
            v[k*4 +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    // Issue one job on the chosen instance and check latency, handshake and result.
    // Called at a negedge; returns at the negedge after done_tick.
    task automatic run_job(input bit use4, input logic [15:0] v, input bit disturb, input string tag);
        int exp_val, exp_lat, lat, waited, low_cnt;
        bit bad;
        ref_model(v, use4 ? 4 : 3, exp_val, bad);
        exp_lat = (bad && CHECK_EN) ? 1 : (use4 ? 15 : 11);
        waited  = 0;
        while (!(use4 ? ready4 : ready3) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check_val({tag, " ready_before_start"}, 32'(use4 ? ready4 : ready3), 1);
        if (use4) begin
            bcd4   = v;
            start4 = 1'b1;
        end else begin
            bcd3   = v[11:0];
            start3 = 1'b1;
        end
        @(posedge clk);
        #1;
        start3 = 1'b0;
        start4 = 1'b0;
        lat     = -1;
        low_cnt = 0;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            @(negedge clk);
            if (disturb && !use4) begin
                if (i == 3) begin
                    start3 = 1'b1;
                    bcd3   = 12'h456;
                end
                if (i == 6) start3 = 1'b0;
            end
            if (!(use4 ? ready4 : ready3)) low_cnt++;
            if (use4 ? done4 : done3) lat = i;
        end
        check_val({tag, " latency"}, 32'(lat), exp_lat);
        check_val({tag, " ready_low_cycles"}, 32'(low_cnt), exp_lat);
        check_val({tag, " err"}, 32'(use4 ? err4 : err3), (bad && CHECK_EN) ? 1 : 0);
        if (!bad) begin
            check_val({tag, " bin"}, 32'(use4 ? bin4 : bin3), exp_val);
        end else if (CHECK_EN) begin
            check_val({tag, " bin_on_err"}, 32'(use4 ? bin4 : bin3), 0);
        end
        @(negedge clk);
        check_val({tag, " done_single"}, 32'(use4 ? done4 : done3), 0);
        check_val({tag, " ready_after"}, 32'(use4 ? ready4 : ready3), 1);
    endtask

    initial begin
        int seen;
        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst ready3", 32'(ready3), 1);
        check_val("rst done3", 32'(done3), 0);
        check_val("rst err3", 32'(err3), 0);
        check_val("rst bin3", 32'(bin3), 0);
        check_val("rst bin4", 32'(bin4), 0);
        check_val("rst ready4", 32'(ready4), 1);
        reset = 1'b0;
        @(negedge clk);

        // Directed jobs
        run_job(1'b0, 16'h0999, 1'b0, "j999");
        run_job(1'b0, 16'h0000, 1'b0, "j000");
        run_job(1'b0, 16'h0001, 1'b0, "j001");
        run_job(1'b0, 16'h0510, 1'b0, "j510");
        run_job(1'b0, 16'h0123, 1'b1, "j123_disturb");

        // Reset in the 5th op cycle aborts the job
        while (!ready3) @(negedge clk);
        bcd3   = 12'h789;
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("abort ready", 32'(ready3), 1);
        check_val("abort bin", 32'(bin3), 0);
        check_val("abort done", 32'(done3), 0);
        reset = 1'b0;
        seen  = 0;
        repeat (15) begin
            @(negedge clk);
            if (done3) seen++;
        end
        check_val("abort no_done", 32'(seen), 0);
        run_job(1'b0, 16'h0042, 1'b0, "j042");

        // Four-digit instance
        run_job(1'b1, 16'h9999, 1'b0, "w9999");
        run_job(1'b1, 16'h1000, 1'b0, "w1000");

        // Invalid digit
        run_job(1'b0, 16'h01A3, 1'b0, "j1A3");

        // Randomized valid jobs
        for (int n = 0; n < 15; n++) begin
            run_job(1'b0, rand_bcd(3), 1'b0, $sformatf("rnd3_%0d", n));
        end
        for (int n = 0; n < 8; n++) begin
            run_job(1'b1, rand_bcd(4), 1'b0, $sformatf("rnd4_%0d", n));
        end
        // Randomized nibbles, possibly invalid
        for (int n = 0; n < 6; n++) begin
            logic [15:0] v;
            v = 16'($urandom_range(0, 4095));
            run_job(1'b0, v, 1'b0, $sformatf("rndx_%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bcd2bin_n.md
Name: bcd2bin_n

Overview:
- Parametrised multi-digit BCD-to-binary converter. Uses an iterative shift-and-subtract-3 datapath with one shift per clock.
- Successor to the fixed 2-digit, 7-bit converter. Generalised to DIGITS decimal digits and a BIN_W-bit result, and adds invalid-digit reporting.
- Sits between keypad/display-side BCD sources and binary arithmetic units.
- Uses the standard start/ready/done_tick FSMD handshake.

Parameters:
- DIGITS, 3: number of 4-bit BCD digits in the input.
- BIN_W, 10: result width and iteration count. Must satisfy 2^BIN_W >= 10^DIGITS. Required values: 4 for DIGITS=1, 7 for 2, 10 for 3, 14 for 4.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a conversion; sampled only in idle.
- bcd  in  4*DIGITS  packed BCD digits; digit 0 in bits [3:0], most significant digit in the top nibble.
- ready  out  1  high while in idle; combinational from state.
- done_tick  out  1  one-cycle pulse marking that bin/err are valid.
- err  out  1  invalid-digit flag, registered and valid with done_tick.
- bin  out  BIN_W  binary result, registered.

Behaviour:
- Reset is synchronous and active-high:
  - state=idle, bin=0, err=0, iteration counter=0, internal BCD register=0.
  - Outputs during and after reset: done_tick=0, ready=1.
  - Reset in any state, including mid-conversion, aborts at that edge. No done_tick is generated for the aborted job.
- States are idle, op, done; unused encodings go to idle.
- idle:
  - ready=1.
  - On a clk edge with start=1: capture bcd into the internal register, load counter=BIN_W, go to op.
  - bin and err hold their previous values until the next start is accepted.
- op:
  - ready=0, done_tick=0.
  - Each cycle:
    - Shift the combined {bcd_reg, bin_reg} right by one.
    - bcd_reg bit 0 enters bin_reg MSB; 0 enters the top of bcd_reg.
    - After the shift, every digit >= 8 has 3 subtracted (4-bit arithmetic, per digit, in parallel).
  - Decrement the counter each cycle. After the BIN_W-th shift, go to done.
- done:
  - done_tick=1 for exactly one cycle, then go to idle.
  - bin holds the final value.
- Latency: if start is sampled at edge k, done_tick is high in the cycle following edge k+BIN_W, and ready returns high after edge k+BIN_W+1.
  - Throughput is one conversion per BIN_W+2 cycles.
- start is ignored while in op or done. No queuing: a pulse in those states is lost.
- bcd is sampled only on the accept edge; changes to bcd afterwards have no effect on the job.
- Overflow cannot occur given the BIN_W constraint. The top bits are 0 for small inputs.
- The result equals the decimal value of bcd for all valid inputs.

Optional Feature:
- Macro: BCD2BIN_DIGIT_CHECK_EN.
- Defined:
  - On the accept edge, each nibble of bcd is checked against > 9.
  - If any nibble is invalid: skip op, go directly to done with err=1 and bin=0. done_tick fires 1 cycle after the accept edge.
  - Otherwise err=0 and the conversion runs normally.
- Undefined:
  - err is held at 0. No check logic is present.
  - Invalid nibbles are processed by the same datapath. The result is deterministic but not meaningful.

Decomposition:
- Shared package (bcd_pkg) holds:
  - The state encoding localparams (idle/op/done).
  - Digit width constant 4.
  - A function returning the minimum BIN_W for a given DIGITS, used by an elaboration-time check.
- Sub-module bcd_digit_adj: 4-bit combinational "if >= 8 subtract 3" cell, instantiated DIGITS times in a generate loop.

Test Plan:
- DIGITS=3, BIN_W=10, bcd=12'h999, start pulse → done_tick 11 cycles after accept edge, bin=10'd999 (0x3E7), err=0.
- bcd=12'h000 then 12'h001 then 12'h510 back-to-back, each started on the first ready cycle → bin=0, 1, 510. Exactly one done_tick each; ready low 11 cycles per job.
- Start accepted with bcd=12'h123; toggle start and change bcd to 12'h456 during op → single done_tick, bin=123.
- Assert reset on the 5th op cycle → next cycle state=idle, ready=1, bin=0, and no done_tick appears. A new start with 12'h042 → bin=42.
- DIGITS=4, BIN_W=14: bcd=16'h9999 → bin=14'd9999 (0x270F). bcd=16'h1000 → 1000.
- With BCD2BIN_DIGIT_CHECK_EN, bcd=12'h1A3 → done_tick 1 cycle after accept, err=1, bin=0. Without the macro the same stimulus gives err=0 and done_tick after 11 cycles.
